inst_fetch: RTL

Instruction-fetch stage of the pipelined RV32I core, sitting directly upstream of the IF/ID pipeline register. It owns the program counter, a direct-mapped one-word-per-line instruction cache, and a word-fetch request port to the memory controller. Each cycle it presents `if_pc`, `if_inst` and `if_stall` to IF/ID, and it accepts redirects (`jump_or_not` / `jump_addr`) from EX.

---
 rtl/inst_fetch.sv | 86 ++++++++
 1 files changed

// File: rtl/inst_fetch.sv
// inst_fetch: RV32I fetch stage with PC, direct-mapped one-word-per-line I-cache and memory fetch port
module inst_fetch #(
  parameter int CACHE_LINES = 128,
  parameter int ADDR_LEN = 32,
  parameter int INST_LEN = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                if_id_stall,
  input  logic                jump_or_not,
  input  logic [ADDR_LEN-1:0] jump_addr,
  output logic                mem_req,
  output logic [ADDR_LEN-1:0] mem_addr,
  input  logic                mem_done,
  input  logic [INST_LEN-1:0] mem_inst,
  output logic [ADDR_LEN-1:0] if_pc,
  output logic [INST_LEN-1:0] if_inst,
  output logic                if_stall
);
  localparam int IDX = $clog2(CACHE_LINES);
  localparam int TAG = ADDR_LEN - IDX - 2;
  typedef enum logic [1:0] {LOOKUP, WAIT, DROP} state_t;
  state_t state, state_n;
  logic [ADDR_LEN-1:0] pc, pc_n, miss_addr, miss_n, addr_n;
  logic req_n, fill, hit, unused;
  logic [IDX-1:0] idx, midx;
  logic [CACHE_LINES-1:0] valid;
  logic [TAG-1:0] tags [CACHE_LINES];
  logic [INST_LEN-1:0] data [CACHE_LINES];
  assign idx = pc[IDX+1:2];
  assign midx = miss_addr[IDX+1:2];
  assign hit = valid[idx] && tags[idx] == pc[ADDR_LEN-1:IDX+2];
  assign if_pc = pc;
  assign if_stall = !(state == LOOKUP && hit);
  assign if_inst = if_stall ? '0 : data[idx];
  assign unused = ^{pc[1:0], miss_addr[1:0]};
  // WAIT and DROP differ only in where a redirect leaves us; both keep the request up until mem_done
  always_comb begin
    state_n = state;
    pc_n = pc;
    miss_n = miss_addr;
    req_n = mem_req;
    addr_n = mem_addr;
    fill = 1'b0;
    if (rdy)
      case (state)
        LOOKUP:
          if (jump_or_not) pc_n = jump_addr;
          else if (hit) pc_n = if_id_stall ? pc : pc + ADDR_LEN'(4);
          else begin
            miss_n = pc;
            addr_n = pc;
            req_n = 1'b1;
            state_n = WAIT;
          end
        default: begin
          fill = mem_done;
          req_n = !mem_done;
          pc_n = jump_or_not ? jump_addr : pc;
          state_n = mem_done ? LOOKUP : (jump_or_not ? DROP : state);
        end
      endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= LOOKUP;
      pc <= '0;
      miss_addr <= '0;
      mem_req <= 1'b0;
      mem_addr <= '0;
      valid <= '0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      miss_addr <= miss_n;
      mem_req <= req_n;
      mem_addr <= addr_n;
      if (fill) valid[midx] <= 1'b1;
    end
  always_ff @(posedge clk)
    if (fill && !rst) begin
      tags[midx] <= miss_addr[ADDR_LEN-1:IDX+2];
      data[midx] <= mem_inst;
    end
endmodule
